ram_selftest: RTL and testbench

RAM_SELFTEST -- requirements
Module: ram_selftest

---
 rtl/ram_selftest.sv | 175 +++++++++++++++++
 tb/tb_ram_selftest.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_selftest.sv
// Write-then-readback RAM self-test: stores a seeded incrementing pattern over
// NUM_ITEMS items, fetches it back and reports mismatch count and first bad address.
package ram_pkg;
  typedef enum logic [1:0] {RAM_BYTE = 2'd0, RAM_WORD = 2'd1, RAM_LONG = 2'd2, RAM_QUAD = 2'd3} ram_size_t;
  typedef enum logic [1:0] {RAM_NOP = 2'd0, RAM_FETCH = 2'd1, RAM_STORE = 2'd2} ram_op_t;
endpackage

module ram_selftest #(
  parameter int unsigned      ADDRW       = 17,
  parameter int unsigned      DATAW       = 64,
  parameter int unsigned      INIT_CYCLES = 60,
  parameter int unsigned      NUM_ITEMS   = 16,
  parameter logic [ADDRW-1:0] BASE_ADDR   = '0,
  parameter int unsigned      RD_LATENCY  = 1,
  parameter logic [63:0]      SEED        = 64'h0102030405060708
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  ram_pkg::ram_size_t size,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [ADDRW-1:0]   first_err_addr,
  output ram_pkg::ram_op_t   ram_op,
  output ram_pkg::ram_size_t ram_size,
  output logic [ADDRW-1:0]   ram_addr,
  output logic [DATAW-1:0]   ram_wdata,
  input  logic [DATAW-1:0]   ram_rdata
);
  import ram_pkg::*;

  localparam int unsigned IW = 17;
  localparam int unsigned CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_ITEMS - 1);
  localparam logic [2:0]    LAT_LAST  = 3'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    INIT_WAIT, IDLE, WRITE, WGAP, READ, RWAIT, CHECK, FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    init_cnt;
  logic [2:0]       lat_cnt;
  logic [IW-1:0]    idx;
  logic [ADDRW-1:0] addr_r;
  logic [DATAW-1:0] data_r;
  ram_size_t        size_r;
  logic [DATAW-1:0] mask;
  logic [ADDRW-1:0] step;
  logic             last_item;
  logic             mismatch;

  always_comb begin
    mask = DATAW'(64'hFFFF_FFFF_FFFF_FFFF);
    step = ADDRW'(8);
    case (size_r)
      RAM_BYTE: begin mask = DATAW'(64'hFF);        step = ADDRW'(1); end
      RAM_WORD: begin mask = DATAW'(64'hFFFF);      step = ADDRW'(2); end
      RAM_LONG: begin mask = DATAW'(64'hFFFF_FFFF); step = ADDRW'(4); end
      default:  begin mask = DATAW'(64'hFFFF_FFFF_FFFF_FFFF); step = ADDRW'(8); end
    endcase
  end

  assign last_item = (idx == LAST_IDX);
  // data_r runs full width; masking here gives the mod-2^W pattern zero-extended
  assign mismatch  = ((ram_rdata ^ data_r) & mask) != '0;
  assign ram_size  = size_r;
  assign ram_addr  = addr_r;
  assign ram_wdata = data_r & mask;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= INIT_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_op    = RAM_NOP;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      INIT_WAIT: if (init_cnt == INIT_LAST) state_nxt = IDLE;
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        ram_op    = RAM_STORE;
        state_nxt = WGAP;
      end
      WGAP: begin
        busy      = 1'b1;
        state_nxt = last_item ? READ : WRITE;
      end
      READ: begin
        busy      = 1'b1;
        ram_op    = RAM_FETCH;
        state_nxt = (RD_LATENCY <= 1) ? CHECK : RWAIT;
      end
      RWAIT: begin
        busy = 1'b1;
        if (lat_cnt == LAT_LAST) state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = last_item ? FINISH : READ;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT_WAIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      init_cnt       <= '0;
      lat_cnt        <= '0;
      idx            <= '0;
      addr_r         <= '0;
      data_r         <= '0;
      size_r         <= RAM_QUAD;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        INIT_WAIT: if (init_cnt != INIT_LAST) init_cnt <= init_cnt + 1'b1;
        IDLE: if (start) begin
          size_r         <= size;
          err_count      <= '0;
          first_err_addr <= '0;
          pass           <= 1'b0;
          idx            <= '0;
          addr_r         <= BASE_ADDR;
          data_r         <= DATAW'(SEED);
        end
        WGAP: begin
          if (last_item) begin
            idx    <= '0;
            addr_r <= BASE_ADDR;
            data_r <= DATAW'(SEED);
          end else begin
            idx    <= idx + 1'b1;
            addr_r <= addr_r + step;
            data_r <= data_r + 1'b1;
          end
        end
        READ:  lat_cnt <= 3'd1;
        RWAIT: lat_cnt <= lat_cnt + 1'b1;
        CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_addr <= addr_r;
          end
          if (last_item) begin
            pass <= (err_count == '0) && !mismatch;
          end else begin
            idx    <= idx + 1'b1;
            addr_r <= addr_r + step;
            data_r <= data_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_selftest.sv
// Bench for ram_selftest: three parameterisations against a latency-modelled RAM,
// a vector table of test passes plus init-wait and mid-read reset sequences.
module tb_ram_selftest;
  import ram_pkg::*;

  localparam logic [63:0] S = 64'h0102030405060708;

  logic        clk = 1'b0;
  logic [2:0]  rst_n = 3'b000;
  logic [2:0]  start = 3'b000;
  logic [2:0]  ready, busy, done, pass;
  ram_size_t   size_in [3];
  logic [15:0] err_count [3];
  logic [16:0] first_err_addr [3];
  ram_op_t     ram_op [3];
  ram_size_t   ram_size [3];
  logic [16:0] ram_addr [3];
  logic [63:0] ram_wdata [3];
  logic [63:0] ram_rdata [3];

  always #5 clk = ~clk;

  ram_selftest #(.ADDRW(17), .DATAW(64), .INIT_CYCLES(60), .NUM_ITEMS(4), .BASE_ADDR(17'h0),
                 .RD_LATENCY(1), .SEED(S)) u_dut0 (
    .CLK(clk), .RST_N(rst_n[0]), .start(start[0]), .size(size_in[0]), .ready(ready[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .first_err_addr(first_err_addr[0]), .ram_op(ram_op[0]), .ram_size(ram_size[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]));

  ram_selftest #(.ADDRW(17), .DATAW(64), .INIT_CYCLES(60), .NUM_ITEMS(4), .BASE_ADDR(17'h0),
                 .RD_LATENCY(3), .SEED(64'hFE)) u_dut1 (
    .CLK(clk), .RST_N(rst_n[1]), .start(start[1]), .size(size_in[1]), .ready(ready[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .first_err_addr(first_err_addr[1]), .ram_op(ram_op[1]), .ram_size(ram_size[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]));

  ram_selftest #(.ADDRW(17), .DATAW(64), .INIT_CYCLES(60), .NUM_ITEMS(2), .BASE_ADDR(17'h1FFF8),
                 .RD_LATENCY(1), .SEED(S)) u_dut2 (
    .CLK(clk), .RST_N(rst_n[2]), .start(start[2]), .size(size_in[2]), .ready(ready[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err_count[2]),
    .first_err_addr(first_err_addr[2]), .ram_op(ram_op[2]), .ram_size(ram_size[2]),
    .ram_addr(ram_addr[2]), .ram_wdata(ram_wdata[2]), .ram_rdata(ram_rdata[2]));

  // RAM model state and transaction log, one slot per instance
  logic [63:0] mem [3][256];
  logic [63:0] pipe [3][3];
  logic [2:0]  log_clr = 3'b000;
  ram_size_t   cur_size [3];
  logic [2:0]  flip_en = 3'b000, flip_all = 3'b000, junk = 3'b000;
  logic [16:0] flip_adr [3];
  int          cyc = 0;
  int          st_cnt [3], fe_cnt [3], st_gmin [3], fe_gmin [3], st_last [3], fe_first [3];
  int          size_bad [3], nonnop [3], done_cnt [3];
  logic [16:0] st_addr [3][4], fe_addr [3][4];
  logic [63:0] st_data [3][4];

  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];
  assign ram_rdata[2] = pipe[2][0];

  function automatic logic [63:0] model_rd(input int k, input logic [16:0] a);
    logic [63:0] v;
    v = mem[k][a[7:0]];
    if (flip_en[k] && (flip_all[k] || a == flip_adr[k])) v = v ^ 64'h1;
    if (junk[k]) v = v | 64'hA5A5_A5A5_A5A5_0000;
    return v;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      st_cnt[k] = 0; fe_cnt[k] = 0; st_gmin[k] = 1000; fe_gmin[k] = 1000; st_last[k] = 0;
      fe_first[k] = 0; size_bad[k] = 0; nonnop[k] = 0; done_cnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      pipe[k][0] <= 64'hDEAD_BEEF_DEAD_BEEF;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
      if (ram_op[k] != RAM_NOP) nonnop[k] <= nonnop[k] + 1;
      if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
      if (log_clr[k]) begin
        st_cnt[k] <= 0; fe_cnt[k] <= 0; st_gmin[k] <= 1000; fe_gmin[k] <= 1000; size_bad[k] <= 0;
      end else if (ram_op[k] == RAM_STORE) begin
        mem[k][ram_addr[k][7:0]] <= ram_wdata[k];
        if (st_cnt[k] < 4) begin
          st_addr[k][st_cnt[k]] <= ram_addr[k];
          st_data[k][st_cnt[k]] <= ram_wdata[k];
        end
        if (st_cnt[k] > 0 && cyc - st_last[k] < st_gmin[k]) st_gmin[k] <= cyc - st_last[k];
        if (ram_size[k] != cur_size[k]) size_bad[k] <= size_bad[k] + 1;
        st_last[k] <= cyc;
        st_cnt[k]  <= st_cnt[k] + 1;
      end else if (ram_op[k] == RAM_FETCH) begin
        pipe[k][0] <= model_rd(k, ram_addr[k]);
        if (fe_cnt[k] < 4) fe_addr[k][fe_cnt[k]] <= ram_addr[k];
        if (fe_cnt[k] == 0) fe_first[k] <= cyc;
        if (fe_cnt[k] > 0 && cyc - st_last[k] < fe_gmin[k]) fe_gmin[k] <= cyc - st_last[k];
        if (ram_size[k] != cur_size[k]) size_bad[k] <= size_bad[k] + 1;
        st_last[k] <= st_last[k];
        fe_cnt[k]  <= fe_cnt[k] + 1;
      end
    end
  end

  // fetch spacing needs its own timestamp; kept separate from the store timestamp
  int fe_last [3];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (ram_op[k] == RAM_FETCH) fe_last[k] <= cyc;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_op", 64'(ram_op[k]), 64'(RAM_NOP));
    chk("rst_ready", 64'(ready[k]), 0);
    chk("rst_busy", 64'(busy[k]), 0);
    chk("rst_done", 64'(done[k]), 0);
    chk("rst_pass", 64'(pass[k]), 0);
    chk("rst_err", 64'(err_count[k]), 0);
    chk("rst_first", 64'(first_err_addr[k]), 0);
    chk("rst_addr", 64'(ram_addr[k]), 0);
    chk("rst_wdata", ram_wdata[k], 0);
    chk("rst_size", 64'(ram_size[k]), 64'(RAM_QUAD));
  endtask

  typedef struct {
    int          dut;
    ram_size_t   sz;
    bit          fe, fa, jk, ep;
    logic [16:0] fadr;
    int          ee;
    logic [16:0] ef;
    int          n, fg;
    logic [16:0] a [4];
    logic [63:0] d [4];
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input int dut, input ram_size_t sz, input bit fe, input bit fa,
                         input logic [16:0] fadr, input bit jk, input bit ep, input int ee,
                         input logic [16:0] ef, input int n, input int fg,
                         input logic [16:0] a0, input logic [16:0] a1, input logic [16:0] a2,
                         input logic [16:0] a3, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [63:0] d3);
    vec_t v;
    v.dut = dut; v.sz = sz; v.fe = fe; v.fa = fa; v.fadr = fadr; v.jk = jk; v.ep = ep;
    v.ee = ee; v.ef = ef; v.n = n; v.fg = fg;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    int w;
    k = v.dut;
    cur_size[k] = v.sz; size_in[k] = v.sz;
    flip_en[k] = v.fe; flip_all[k] = v.fa; flip_adr[k] = v.fadr; junk[k] = v.jk;
    start[k] = 1'b1; log_clr[k] = 1'b1;
    tick();
    start[k] = 1'b0; log_clr[k] = 1'b0;
    chk("acc_busy", 64'(busy[k]), 1);
    chk("acc_ready", 64'(ready[k]), 0);
    chk("acc_pass_clr", 64'(pass[k]), 0);
    chk("acc_err_clr", 64'(err_count[k]), 0);
    w = 0;
    while (!done[k] && w < 400) begin
      tick();
      w++;
    end
    chk("done_seen", 64'(done[k]), 1);
    chk("pass", 64'(pass[k]), 64'(v.ep));
    chk("err_count", 64'(err_count[k]), 64'(v.ee));
    chk("first_err_addr", 64'(first_err_addr[k]), 64'(v.ef));
    chk("done_busy", 64'(busy[k]), 0);
    tick();
    chk("done_pulse_end", 64'(done[k]), 0);
    chk("ready_again", 64'(ready[k]), 1);
    chk("pass_held", 64'(pass[k]), 64'(v.ep));
    chk("store_cnt", 64'(st_cnt[k]), 64'(v.n));
    chk("fetch_cnt", 64'(fe_cnt[k]), 64'(v.n));
    for (int i = 0; i < v.n; i++) begin
      chk("store_addr", 64'(st_addr[k][i]), 64'(v.a[i]));
      chk("store_data", st_data[k][i], v.d[i]);
      chk("fetch_addr", 64'(fe_addr[k][i]), 64'(v.a[i]));
    end
    chk("store_gap", 64'(st_gmin[k]), 2);
    chk("fetch_gap", 64'(fe_gmin[k] == 1000 ? 0 : fe_gmin[k]), 64'(v.n > 1 ? v.fg : 0));
    chk("phase_order", 64'(fe_first[k] - st_last[k] >= 2), 1);
    chk("size_latched", 64'(size_bad[k]), 0);
  endtask

  // fetch gap in the monitor is measured against fe_last via this alias
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (ram_op[k] == RAM_FETCH && fe_cnt[k] > 0 && !log_clr[k] && cyc - fe_last[k] < fe_gmin[k])
        fe_gmin[k] <= cyc - fe_last[k];
  end

  initial begin
    int w;
    int dc;
    int nn;
    for (int k = 0; k < 3; k++) begin
      size_in[k] = RAM_QUAD; cur_size[k] = RAM_QUAD; flip_adr[k] = '0; fe_last[k] = 0;
    end

    add_vec(0, RAM_QUAD, 0, 0, 17'h0, 0, 1, 0, 17'h0, 4, 2, 17'd0, 17'd8, 17'd16, 17'd24,
            S, S + 64'd1, S + 64'd2, S + 64'd3);
    add_vec(1, RAM_BYTE, 0, 0, 17'h0, 0, 1, 0, 17'h0, 4, 4, 17'd0, 17'd1, 17'd2, 17'd3,
            64'hFE, 64'hFF, 64'h00, 64'h01);
    add_vec(0, RAM_QUAD, 1, 0, 17'd16, 0, 0, 1, 17'd16, 4, 2, 17'd0, 17'd8, 17'd16, 17'd24,
            S, S + 64'd1, S + 64'd2, S + 64'd3);
    add_vec(0, RAM_WORD, 0, 0, 17'h0, 1, 1, 0, 17'h0, 4, 2, 17'd0, 17'd2, 17'd4, 17'd6,
            64'h0708, 64'h0709, 64'h070A, 64'h070B);
    add_vec(2, RAM_QUAD, 0, 0, 17'h0, 0, 1, 0, 17'h0, 2, 2, 17'h1FFF8, 17'h0, 17'h0, 17'h0,
            S, S + 64'd1, 64'h0, 64'h0);
    add_vec(1, RAM_QUAD, 1, 0, 17'd8, 0, 0, 1, 17'd8, 4, 4, 17'd0, 17'd8, 17'd16, 17'd24,
            64'hFE, 64'hFF, 64'h100, 64'h101);
    add_vec(2, RAM_QUAD, 1, 1, 17'h0, 0, 0, 2, 17'h1FFF8, 2, 2, 17'h1FFF8, 17'h0, 17'h0, 17'h0,
            S, S + 64'd1, 64'h0, 64'h0);
    add_vec(0, RAM_LONG, 0, 0, 17'h0, 0, 1, 0, 17'h0, 4, 2, 17'd0, 17'd4, 17'd8, 17'd12,
            64'h05060708, 64'h05060709, 64'h0506070A, 64'h0506070B);
    add_vec(1, RAM_WORD, 0, 0, 17'h0, 0, 1, 0, 17'h0, 4, 4, 17'd0, 17'd2, 17'd4, 17'd6,
            64'h00FE, 64'h00FF, 64'h0100, 64'h0101);

    // held in reset
    repeat (3) tick();
    for (int k = 0; k < 3; k++) chk_reset_vals(k);

    // release; a start at the 10th posedge must be ignored, ready after exactly 60
    rst_n = 3'b111;
    repeat (9) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (49) tick();
    for (int k = 0; k < 3; k++) chk("init_ready_59", 64'(ready[k]), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("init_ready_60", 64'(ready[k]), 1);
      chk("init_nop", 64'(nonnop[k]), 0);
    end
    chk("init_start_ignored", 64'(busy[0]), 0);
    tick();
    chk("idle_stays", 64'(busy[0]), 0);

    foreach (vq[i]) run_vec(vq[i]);

    // reset during read phase of the latency-3 instance
    cur_size[1] = RAM_BYTE; size_in[1] = RAM_BYTE; flip_en[1] = 0; junk[1] = 0;
    start[1] = 1'b1; log_clr[1] = 1'b1;
    tick();
    start[1] = 1'b0; log_clr[1] = 1'b0;
    w = 0;
    while (fe_cnt[1] < 2 && w < 200) begin
      tick();
      w++;
    end
    chk("mid_read_reached", 64'(fe_cnt[1] >= 2), 1);
    chk("mid_fetch_gap", 64'(fe_gmin[1]), 4);
    tick();
    dc = done_cnt[1];
    #2 rst_n[1] = 1'b0;
    #1 chk_reset_vals(1);
    repeat (3) tick();
    nn = nonnop[1];
    rst_n[1] = 1'b1;
    repeat (59) tick();
    chk("rearm_ready_59", 64'(ready[1]), 0);
    tick();
    chk("rearm_ready_60", 64'(ready[1]), 1);
    chk("abort_no_done", 64'(done_cnt[1] - dc), 0);
    chk("rearm_nop", 64'(nonnop[1] - nn), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
